sounder_ctrl: RTL and testbench

SOUNDER_CTRL -- requirements
Module: sounder_ctrl

---
 rtl/sounder_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sounder_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sounder_ctrl.sv
// Sounder sequencer: a serial register bank plus an IDLE/ARM/RUN/DRAIN FSM.
// It paces PN-generator chip strobes and counts periods for finite or free-running runs.
module sounder_ctrl #(
    parameter logic [6:0] BASE = 7'd64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  saddr_i,
    input  logic [31:0] sdata_i,
    input  logic        sstrobe_i,
    output logic        tx_ena_o,
    output logic        rx_ena_o,
    output logic        loopback_o,
    output logic        chip_strobe_o,
    output logic        pn_rst_o,
    output logic [15:0] mask_o,
    output logic [13:0] ampl_o,
    output logic        period_end_o,
    output logic        done_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    state_t state, state_nxt;

    logic [2:0]  ctrl_r;
    logic [4:0]  degree_r;
    logic [13:0] ampl_r;
    logic [15:0] div_r;
    logic [15:0] nper_r;

    logic [2:0]  run_ctrl;
    logic [15:0] mask_lat;
    logic [15:0] last_chip;
    logic [15:0] div_lat;
    logic [15:0] nper_lat;
    logic [15:0] div_cnt;
    logic [15:0] chip_cnt;
    logic [15:0] per_cnt;

    logic wr_ctrl, wr_degree, wr_ampl, wr_div, wr_nper;
    logic start_req, stop_req, deg_ok, active;
    logic chip_strobe, period_end, run_done;
    logic unused_sdata;

    function automatic logic [15:0] mask_for(input logic [4:0] deg);
        logic [15:0] m;
        case (deg)
            5'd2:    m = 16'h0003;
            5'd3:    m = 16'h0006;
            5'd4:    m = 16'h000C;
            5'd5:    m = 16'h0014;
            5'd6:    m = 16'h0030;
            5'd7:    m = 16'h0060;
            5'd8:    m = 16'h00B8;
            5'd9:    m = 16'h0110;
            5'd10:   m = 16'h0240;
            5'd11:   m = 16'h0500;
            5'd12:   m = 16'h0E08;
            5'd13:   m = 16'h1C80;
            5'd14:   m = 16'h3802;
            5'd15:   m = 16'h6000;
            5'd16:   m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    // Last chip index of a period is L-1 = 2^deg - 2; deg 16 needs the 17-bit intermediate.
    function automatic logic [15:0] last_chip_for(input logic [4:0] deg);
        logic [16:0] full;
        full = (17'd1 << deg) - 17'd2;
        return full[15:0];
    endfunction

    assign wr_ctrl   = sstrobe_i && (saddr_i == BASE);
    assign wr_degree = sstrobe_i && (saddr_i == BASE + 7'd1);
    assign wr_ampl   = sstrobe_i && (saddr_i == BASE + 7'd2);
    assign wr_div    = sstrobe_i && (saddr_i == BASE + 7'd3);
    assign wr_nper   = sstrobe_i && (saddr_i == BASE + 7'd4);

    assign start_req = wr_ctrl && (sdata_i[1:0] != 2'b00);
    assign stop_req  = wr_ctrl && (sdata_i[1:0] == 2'b00);
    assign deg_ok    = (degree_r >= 5'd2) && (degree_r <= 5'd16);
    assign active    = (state == RUN) || (state == DRAIN);

    assign chip_strobe = active && (div_cnt == 16'd0);
    assign period_end  = chip_strobe && (chip_cnt == last_chip);
    assign run_done    = period_end && (nper_lat != 16'd0) && (per_cnt == nper_lat - 16'd1);

    assign unused_sdata = &{1'b0, sdata_i[31:16]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_req && deg_ok) state_nxt = ARM;
            ARM:   state_nxt = RUN;
            RUN: begin
                if (run_done || (stop_req && period_end)) state_nxt = IDLE;
                else if (stop_req)                         state_nxt = DRAIN;
            end
            DRAIN: if (period_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            ctrl_r   <= '0;
            degree_r <= '0;
            ampl_r   <= '0;
            div_r    <= '0;
            nper_r   <= '0;
            run_ctrl <= '0;
            mask_lat <= '0;
            last_chip <= '0;
            div_lat  <= '0;
            nper_lat <= '0;
            div_cnt  <= '0;
            chip_cnt <= '0;
            per_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (wr_ctrl)   ctrl_r   <= sdata_i[2:0];
            if (wr_degree) degree_r <= sdata_i[4:0];
            if (wr_ampl)   ampl_r   <= sdata_i[13:0];
            if (wr_div)    div_r    <= sdata_i[15:0];
            if (wr_nper)   nper_r   <= sdata_i[15:0];

            case (state)
                ARM: begin
                    run_ctrl  <= ctrl_r;
                    mask_lat  <= mask_for(degree_r);
                    last_chip <= last_chip_for(degree_r);
                    div_lat   <= div_r;
                    nper_lat  <= nper_r;
                    div_cnt   <= '0;
                    chip_cnt  <= '0;
                    per_cnt   <= '0;
                end
                RUN, DRAIN: begin
                    // Enable changes apply live while running; a stop write leaves them for the drain.
                    if (state == RUN && start_req) run_ctrl <= sdata_i[2:0];
                    div_cnt <= (div_cnt == div_lat) ? 16'd0 : div_cnt + 16'd1;
                    if (chip_strobe) chip_cnt <= period_end ? 16'd0 : chip_cnt + 16'd1;
                    if (period_end)  per_cnt  <= per_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign tx_ena_o      = active && run_ctrl[0];
    assign rx_ena_o      = active && run_ctrl[1];
    assign loopback_o    = active && run_ctrl[2];
    assign chip_strobe_o = chip_strobe;
    assign pn_rst_o      = (state == ARM);
    assign mask_o        = mask_lat;
    assign ampl_o        = ampl_r;
    assign period_end_o  = period_end;
    assign done_o        = run_done;
    assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_sounder_ctrl.sv
// Randomised bench for sounder_ctrl: outputs are compared each cycle against a
// run-time arithmetic model, plus directed scenarios with hand-computed expectations.
module tb_sounder_ctrl;

    localparam logic [6:0] BASE = 7'd64;

    logic        clk;
    logic        rst;
    logic [6:0]  saddr;
    logic [31:0] sdata;
    logic        sstrobe;
    logic        tx_ena, rx_ena, loopback, chip_strobe, pn_rst, period_end, done, busy;
    logic [15:0] mask;
    logic [13:0] ampl;

    sounder_ctrl #(.BASE(BASE)) dut (
        .clk_i(clk), .rst_i(rst), .saddr_i(saddr), .sdata_i(sdata), .sstrobe_i(sstrobe),
        .tx_ena_o(tx_ena), .rx_ena_o(rx_ena), .loopback_o(loopback),
        .chip_strobe_o(chip_strobe), .pn_rst_o(pn_rst), .mask_o(mask), .ampl_o(ampl),
        .period_end_o(period_end), .done_o(done), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_pe = 0;
    int n_done = 0;
    bit cmp_on = 1'b0;

    // Model: mode 0 idle, 1 arm, 2 run, 3 drain; k counts cycles since the first run cycle.
    int          m_mode = 0;
    logic [2:0]  m_ctrl = '0;
    logic [4:0]  m_deg = '0;
    logic [13:0] m_ampl = '0;
    logic [15:0] m_div = '0;
    logic [15:0] m_nper = '0;
    logic [15:0] l_mask = '0;
    logic [2:0]  l_en = '0;
    longint      l_len = 1;
    longint      l_div = 0;
    longint      l_nper = 0;
    longint      k = 0;
    logic [15:0] mask_tab [0:31];

    initial begin
        for (int i = 0; i < 32; i++) mask_tab[i] = 16'h0000;
        mask_tab[2] = 16'h0003;  mask_tab[3] = 16'h0006;  mask_tab[4] = 16'h000C;
        mask_tab[5] = 16'h0014;  mask_tab[6] = 16'h0030;  mask_tab[7] = 16'h0060;
        mask_tab[8] = 16'h00B8;  mask_tab[9] = 16'h0110;  mask_tab[10] = 16'h0240;
        mask_tab[11] = 16'h0500; mask_tab[12] = 16'h0E08; mask_tab[13] = 16'h1C80;
        mask_tab[14] = 16'h3802; mask_tab[15] = 16'h6000; mask_tab[16] = 16'hD008;
    end

    function automatic bit hit(input int off);
        return sstrobe && (saddr == BASE + 7'(off));
    endfunction
    function automatic bit f_start();
        return hit(0) && (sdata[1:0] != 2'b00);
    endfunction
    function automatic bit f_stop();
        return hit(0) && (sdata[1:0] == 2'b00);
    endfunction
    function automatic bit f_strobe();
        return (m_mode >= 2) && (k % (l_div + 1) == 0);
    endfunction
    function automatic bit f_pe();
        return f_strobe() && (((k / (l_div + 1)) % l_len) == l_len - 1);
    endfunction
    function automatic bit f_done();
        return f_pe() && (l_nper != 0) && ((k / (l_div + 1)) / l_len + 1 == l_nper);
    endfunction

    function automatic logic [37:0] exp_vec();
        bit act;
        act = (m_mode >= 2);
        return {act & l_en[0], act & l_en[1], act & l_en[2], f_strobe(), m_mode == 1,
                l_mask, m_ampl, f_pe(), f_done(), m_mode != 0};
    endfunction

    function automatic logic [37:0] dut_vec();
        return {tx_ena, rx_ena, loopback, chip_strobe, pn_rst, mask, ampl, period_end, done, busy};
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_mode <= 0; m_ctrl <= '0; m_deg <= '0; m_ampl <= '0; m_div <= '0; m_nper <= '0;
            l_mask <= '0; l_en <= '0; l_len <= 1; l_div <= 0; l_nper <= 0; k <= 0;
        end else begin
            if (hit(0)) m_ctrl <= sdata[2:0];
            if (hit(1)) m_deg  <= sdata[4:0];
            if (hit(2)) m_ampl <= sdata[13:0];
            if (hit(3)) m_div  <= sdata[15:0];
            if (hit(4)) m_nper <= sdata[15:0];
            case (m_mode)
                0: if (f_start() && m_deg >= 2 && m_deg <= 16) m_mode <= 1;
                1: begin
                    m_mode <= 2;
                    l_mask <= mask_tab[m_deg];
                    l_len  <= (longint'(1) << m_deg) - 1;
                    l_div  <= longint'(m_div);
                    l_nper <= longint'(m_nper);
                    l_en   <= m_ctrl;
                    k      <= 0;
                end
                default: begin
                    k <= k + 1;
                    if (f_done() || (f_pe() && (m_mode == 3 || f_stop()))) m_mode <= 0;
                    else if (m_mode == 2 && f_stop()) m_mode <= 3;
                    else if (m_mode == 2 && f_start()) l_en <= sdata[2:0];
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare against the model mid-cycle, then step past the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (cmp_on) chk("cycle", dut_vec(), exp_vec());
        if (chip_strobe) n_strobe++;
        if (period_end)  n_pe++;
        if (done)        n_done++;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        saddr = BASE + 7'(off);
        sdata = d;
        sstrobe = 1'b1;
        tick();
        sstrobe = 1'b0;
        saddr = '0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        chk("idle_timeout", {37'b0, busy}, 38'd0);
    endtask

    int b_s, b_p, b_d;

    initial begin
        rst = 1'b0; sstrobe = 1'b0; saddr = '0; sdata = '0;
        tick();
        cmp_on = 1'b1;
        tick();
        chk("reset_state", dut_vec(), 38'd0);
        rst = 1'b1;

        // Finite run: deg 3, two periods, tx only
        wr(1, 32'hFFFF_FFE3); wr(3, 0); wr(4, 2);
        b_s = n_strobe; b_p = n_pe; b_d = n_done;
        wr(0, 1);
        chk("arm_pn_rst", {37'b0, pn_rst}, 38'd1);
        wait_idle(100);
        chk("fin_strobes", 38'(n_strobe - b_s), 38'd14);
        chk("fin_pe", 38'(n_pe - b_p), 38'd2);
        chk("fin_done", 38'(n_done - b_d), 38'd1);
        chk("fin_tx_low", {37'b0, tx_ena}, 38'd0);
        chk("fin_mask", {22'b0, mask}, {22'b0, 16'h0006});

        // Free run: deg 4, DIV 2, stopped mid-period
        wr(1, 4); wr(3, 2); wr(4, 0); wr(2, 32'h0001_2ABC);
        chk("ampl_now", {24'b0, ampl}, {24'b0, 14'h2ABC});
        b_s = n_strobe; b_p = n_pe;
        wr(0, 3);
        repeat (200) tick();
        wr(0, 0);
        wait_idle(400);
        chk("free_whole_periods", 38'(n_strobe - b_s), 38'((n_pe - b_p) * 15));
        chk("free_periods", 38'(n_pe - b_p), 38'd5);

        // Invalid degrees never arm
        wr(1, 1); wr(0, 1); repeat (3) tick();
        chk("deg1_busy", {37'b0, busy}, 38'd0);
        chk("deg1_mask", {22'b0, mask}, {22'b0, 16'h000C});
        wr(1, 17); wr(0, 1); repeat (3) tick();
        chk("deg17_busy", {37'b0, busy}, 38'd0);
        chk("deg17_mask", {22'b0, mask}, {22'b0, 16'h000C});

        // Degree change mid-run waits for re-arm
        wr(1, 3); wr(3, 0); wr(0, 5);
        repeat (10) tick();
        wr(1, 8);
        repeat (10) tick();
        chk("mask_held", {22'b0, mask}, {22'b0, 16'h0006});
        wr(0, 0); wait_idle(50);
        wr(0, 1); tick();
        chk("mask_rearm", {22'b0, mask}, {22'b0, 16'h00B8});
        wr(0, 0); wait_idle(600);

        // Reset mid-run at chip 5 of deg 5, then immediate re-arm
        wr(1, 5); wr(0, 1); tick();
        repeat (5) tick();
        rst = 1'b0; tick();
        chk("midrun_reset", dut_vec(), 38'd0);
        rst = 1'b1;
        wr(1, 5); wr(0, 1);
        b_s = n_strobe; b_p = n_pe;
        for (int i = 0; i < 100 && n_pe == b_p; i++) tick();
        chk("rearm_first_period", 38'(n_strobe - b_s), 38'd31);
        wr(0, 0); wait_idle(100);

        // Stop written on a period-end cycle
        wr(1, 2); wr(0, 1);
        for (int i = 0; i < 20 && !f_pe(); i++) tick();
        wr(0, 0);
        chk("stop_on_pe_idle", {37'b0, busy}, 38'd0);
        b_s = n_strobe;
        repeat (5) tick();
        chk("stop_on_pe_quiet", 38'(n_strobe - b_s), 38'd0);

        // Random traffic
        for (int it = 0; it < 4000; it++) begin
            int r;
            logic [31:0] d;
            r = $urandom_range(0, 99);
            d = $urandom;
            if (r < 2) begin
                rst = 1'b0; tick(); rst = 1'b1;
            end else if (r < 14) begin
                int off;
                off = $urandom_range(0, 6);
                case (off)
                    1: begin
                        int dg;
                        dg = $urandom_range(0, 8);
                        d[4:0] = (dg == 8) ? 5'd17 : 5'(dg);
                    end
                    3: d[15:0] = 16'($urandom_range(0, 3));
                    4: d[15:0] = 16'($urandom_range(0, 3));
                    default: ;
                endcase
                wr(off, d);
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
